noise_injector: RTL and testbench
=================================

Name: noise_injector

Overview:
- Synchronous pseudo-random glitch injector, the stimulus-side counterpart of Noise_Eliminator.
- Takes a clean signal `din` and produces `dout`, which is `din` with inversion pulses of bounded width inserted at bounded pseudo-random intervals.
- Used in benches and on-board self-test to drive Noise_Eliminator with repeatable noise.
- Counts injected glitches so that downstream filtering can be scored.

Parameters:
- SEED, 16'hACE1, initial LFSR value; must be non-zero.
- GAP_W, 8, width of `min_gap`.
- WIDTH_W, 4, width of `max_width`; must be ≤ 16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  injection enable.
- din  input  1  clean input signal; assumed already synchronous to clk.
- min_gap  input  GAP_W  minimum idle cycles between glitches.
- max_width  input  WIDTH_W  glitch-width mask; 0 disables injection.
- dout  output  1  noisy output, registered.
- glitch_active  output  1  high while `dout` is inverted relative to `din`, registered.
- glitch_count  output  16  number of glitches started, saturating.

Behaviour:
- Reset values (`rst` = 0, asynchronous):
  - state = IDLE, lfsr = SEED, gap_cnt = 0, width_cnt = 0.
  - dout = 0, glitch_active = 0, glitch_count = 0.
- LFSR:
  - 16-bit Galois, right shift: `lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`.
  - Advances every cycle in WAIT and GLITCH; holds in IDLE.
  - Never reaches zero.
- gap_cnt is GAP_W+1 bits wide; load value G = min_gap + lfsr[3:0], zero-extended, no overflow.
- Width load value W = lfsr[WIDTH_W-1:0] & max_width; if the result is 0, W = 1.
- States:
  - IDLE: if `en` = 1, go to WAIT and load gap_cnt <= G from the current lfsr.
  - WAIT:
    - If gap_cnt ≠ 0, decrement it.
    - If gap_cnt = 0 and max_width ≠ 0, go to GLITCH, load width_cnt <= W, and increment glitch_count (saturates at 16'hFFFF).
    - If gap_cnt = 0 and max_width = 0, stay in WAIT and reload G.
    - WAIT therefore lasts G+1 cycles.
  - GLITCH:
    - If width_cnt = 1, go to WAIT and load a new G; otherwise decrement width_cnt.
    - GLITCH therefore lasts exactly W cycles.
  - `en` = 0 in any state: next state is IDLE; an in-progress glitch is truncated; counters hold.
- Outputs:
  - `dout <= din ^ (state == GLITCH)` and `glitch_active <= (state == GLITCH)`.
  - Both lag the state by one cycle. Latency from `din` to `dout` is 1 cycle in all states.
- `min_gap` and `max_width` are sampled only at load points; changing them mid-interval does not affect the current interval.
- A reset asserted mid-glitch forces `dout` = 0 immediately (asynchronous) and restarts the LFSR from SEED, so the sequence is repeatable.
- Invariant: no two glitches are closer than min_gap+1 cycles apart.

Decomposition:
- Shared package holds:
  - `LFSR_TAPS` = 16'hB400 and `DEFAULT_SEED` = 16'hACE1.
  - The 2-bit state encoding: IDLE = 0, WAIT = 1, GLITCH = 2.
  - `COUNT_MAX` = 16'hFFFF.
- One sub-module, lfsr16, with ports clk, rst, advance, q[15:0] and parameter SEED.
- The FSM, counters and output registers stay in noise_injector.

Test Plan:
1. Reset, then en = 1, din = 0, min_gap = 10, max_width = 0 for 1000 cycles -> dout = 0 throughout, glitch_active = 0, glitch_count = 0.
2. Default SEED, min_gap = 10, max_width = 1, en sampled high at edge k -> dout first goes to 1 at edge k+13 and stays high exactly 1 cycle. Every glitch is 1 cycle wide, gaps are within 11..26 cycles, and glitch_count matches the count of glitch_active pulses.
3. en = 0, din toggled every 7 cycles for 100 cycles -> dout equals din delayed 1 cycle, glitch_active = 0.
4. min_gap = 0, max_width = 4'hF, run 5000 cycles against a reference model of the LFSR/FSM -> dout, glitch_active and glitch_count match the model cycle-exactly, and every glitch width is within 1..15.
5. Drive rst low for 3 ns in the middle of a glitch -> dout and glitch_active drop to 0 without waiting for a clk edge, glitch_count = 0. After rst is released, the glitch timeline repeats exactly as in scenario 2.
6. min_gap = 0, max_width = 1, run until 70000 glitches have been injected -> glitch_count stops at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/noise_injector_pkg.sv
// Shared constants, state encoding and LFSR step function for the noise injector.
package noise_injector_pkg;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        GLITCH = 2'd2
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [15:0] lfsr;
    } dbg_t;

    // Galois right-shift step; a non-zero value never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/noise_injector_lfsr16.sv
// 16-bit Galois LFSR that steps only when advance is high; restarts from SEED on reset.
module lfsr16
    import noise_injector_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/noise_injector.sv
// Pseudo-random glitch injector: inverts din for bounded bursts at bounded random intervals.
// The LFSR supplies gap and width jitter; FSM, counters and output registers live here.
module noise_injector
    import noise_injector_pkg::*;
#(
    parameter logic [15:0] SEED    = DEFAULT_SEED,
    parameter int          GAP_W   = 8,
    parameter int          WIDTH_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               din,
    input  logic [GAP_W-1:0]   min_gap,
    input  logic [WIDTH_W-1:0] max_width,
    output logic               dout,
    output logic               glitch_active,
    output logic [15:0]        glitch_count,
    output dbg_t               o_dbg
);

    state_t             r_state;
    state_t             w_state_next;
    logic [GAP_W:0]     r_gap_cnt;
    logic [GAP_W:0]     w_gap_next;
    logic [WIDTH_W-1:0] r_width_cnt;
    logic [WIDTH_W-1:0] w_width_next;
    logic [15:0]        r_glitch_count;
    logic [15:0]        w_count_next;
    logic               r_dout;
    logic               r_glitch_active;

    logic [15:0]        w_lfsr;
    logic               w_advance;
    logic [GAP_W:0]     w_gap_load;
    logic [WIDTH_W-1:0] w_width_mask;
    logic [WIDTH_W-1:0] w_width_load;
    logic               w_in_glitch;

    assign w_advance = (r_state != IDLE);

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (w_advance),
        .q       (w_lfsr)
    );

    // Extra bit on the gap counter keeps min_gap + jitter from overflowing.
    assign w_gap_load   = {1'b0, min_gap} + (GAP_W+1)'(w_lfsr[3:0]);
    assign w_width_mask = w_lfsr[WIDTH_W-1:0] & max_width;
    assign w_width_load = (w_width_mask == '0) ? WIDTH_W'(1) : w_width_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_gap_cnt      <= '0;
            r_width_cnt    <= '0;
            r_glitch_count <= '0;
        end else begin
            r_state        <= w_state_next;
            r_gap_cnt      <= w_gap_next;
            r_width_cnt    <= w_width_next;
            r_glitch_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap_cnt;
        w_width_next = r_width_cnt;
        w_count_next = r_glitch_count;
        if (!en) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = WAIT;
                    w_gap_next   = w_gap_load;
                end
                WAIT: begin
                    if (r_gap_cnt != '0) begin
                        w_gap_next = r_gap_cnt - 1'b1;
                    end else if (max_width != '0) begin
                        w_state_next = GLITCH;
                        w_width_next = w_width_load;
                        w_count_next = (r_glitch_count == COUNT_MAX) ? COUNT_MAX
                                                                     : r_glitch_count + 16'd1;
                    end else begin
                        w_gap_next = w_gap_load;
                    end
                end
                GLITCH: begin
                    if (r_width_cnt == WIDTH_W'(1)) begin
                        w_state_next = WAIT;
                        w_gap_next   = w_gap_load;
                    end else begin
                        w_width_next = r_width_cnt - 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_in_glitch = (r_state == GLITCH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout          <= 1'b0;
            r_glitch_active <= 1'b0;
        end else begin
            r_dout          <= din ^ w_in_glitch;
            r_glitch_active <= w_in_glitch;
        end
    end

    assign dout          = r_dout;
    assign glitch_active = r_glitch_active;
    assign glitch_count  = r_glitch_count;
    assign o_dbg.state   = r_state;
    assign o_dbg.lfsr    = w_lfsr;

endmodule

// File: tb/tb_noise_injector.sv
// Self-checking bench for noise_injector: cycle-level reference model feeding an expected queue,
// plus scenario tasks for timing, pass-through, async reset and count saturation.
module tb_noise_injector;
    import noise_injector_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        din;
    logic [7:0]  min_gap;
    logic [3:0]  max_width;
    logic        dout;
    logic        ga;
    logic [15:0] gcount;
    dbg_t        dbg;

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_q[$];

    // reference model state
    int          m_state;
    logic [15:0] m_lfsr;
    logic [8:0]  m_gap;
    logic [3:0]  m_width;
    logic [15:0] m_count;
    logic        m_dout;
    logic        m_ga;

    int starts[64];

    always #5 clk = ~clk;

    noise_injector dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .din           (din),
        .min_gap       (min_gap),
        .max_width     (max_width),
        .dout          (dout),
        .glitch_active (ga),
        .glitch_count  (gcount),
        .o_dbg         (dbg)
    );

    initial begin
        #900000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_galois(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_lfsr  = 16'hACE1;
        m_gap   = '0;
        m_width = '0;
        m_count = '0;
        m_dout  = 1'b0;
        m_ga    = 1'b0;
    endtask

    task automatic model_step();
        int          ns;
        logic [8:0]  ng;
        logic [8:0]  gl;
        logic [3:0]  nw;
        logic [3:0]  wl;
        logic [15:0] nc;
        gl = {1'b0, min_gap} + {5'b0, m_lfsr[3:0]};
        wl = m_lfsr[3:0] & max_width;
        if (wl == 4'd0) wl = 4'd1;
        ns = m_state; ng = m_gap; nw = m_width; nc = m_count;
        if (!en) begin
            ns = 0;
        end else if (m_state == 0) begin
            ns = 1; ng = gl;
        end else if (m_state == 1) begin
            if (m_gap != 0) ng = m_gap - 9'd1;
            else if (max_width != 0) begin
                ns = 2; nw = wl;
                if (m_count != 16'hFFFF) nc = m_count + 16'd1;
            end else ng = gl;
        end else begin
            if (m_width == 4'd1) begin ns = 1; ng = gl; end
            else nw = m_width - 4'd1;
        end
        m_dout  = din ^ (m_state == 2);
        m_ga    = (m_state == 2);
        if (m_state != 0) m_lfsr = ref_galois(m_lfsr);
        m_state = ns; m_gap = ng; m_width = nw; m_count = nc;
    endtask

    // One clock: predict, push, let the edge happen, pop and compare, return at negedge.
    task automatic cycle();
        logic [17:0] exp_v;
        logic [17:0] got_v;
        model_step();
        exp_q.push_back({m_dout, m_ga, m_count});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        got_v = {dout, ga, gcount};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL scoreboard t=%0t got dout=%b ga=%b cnt=%h exp dout=%b ga=%b cnt=%h",
                     $time, got_v[17], got_v[16], got_v[15:0], exp_v[17], exp_v[16], exp_v[15:0]);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; din = 1'b0; min_gap = 8'd0; max_width = 4'd0;
        model_reset();
        #12;
        checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", dout); end
        checks++; if (ga !== 1'b0) begin failures++; $display("FAIL reset_ga got=%b exp=0", ga); end
        checks++; if (gcount !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", gcount); end
        checks++; if (dbg.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg.state); end
        checks++; if (dbg.lfsr !== 16'hACE1) begin failures++; $display("FAIL reset_lfsr got=%h exp=ace1", dbg.lfsr); end
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic test_zero_width();
        int hi_seen = 0;
        do_reset();
        en = 1'b1; din = 1'b0; min_gap = 8'd10; max_width = 4'd0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (dout !== 1'b0 || ga !== 1'b0) hi_seen++;
        end
        checks++; if (hi_seen != 0) begin failures++; $display("FAIL zero_width_quiet got=%0d exp=0", hi_seen); end
        checks++; if (gcount !== 16'h0) begin failures++; $display("FAIL zero_width_count got=%h exp=0000", gcount); end
    endtask

    // Default seed, min_gap=10, max_width=1; first posedge after entry is edge k.
    task automatic run_timeline(input int n_cycles, input bit replay);
        int first_hi = -1;
        int run_lo   = 0;
        int run_hi   = 0;
        int pulses   = 0;
        en = 1'b1; din = 1'b0; min_gap = 8'd10; max_width = 4'd1;
        for (int i = 1; i <= n_cycles; i++) begin
            cycle();
            if (ga) begin
                if (run_hi == 0) begin
                    if (pulses < 64) begin
                        if (replay) begin
                            checks++;
                            if (starts[pulses] != i) begin
                                failures++;
                                $display("FAIL replay_start idx=%0d got=%0d exp=%0d", pulses, i, starts[pulses]);
                            end
                        end else starts[pulses] = i;
                    end
                    if (first_hi < 0) first_hi = i;
                    else begin
                        checks++;
                        if (run_lo < 11 || run_lo > 26) begin
                            failures++;
                            $display("FAIL glitch_gap got=%0d exp=11..26", run_lo);
                        end
                    end
                    pulses++;
                end
                run_hi++; run_lo = 0;
            end else begin
                if (run_hi != 0) begin
                    checks++;
                    if (run_hi != 1) begin failures++; $display("FAIL glitch_width1 got=%0d exp=1", run_hi); end
                end
                run_hi = 0; run_lo++;
            end
        end
        checks++; if (first_hi != 14) begin failures++; $display("FAIL first_glitch_edge got=k+%0d exp=k+13", first_hi - 1); end
        checks++; if (gcount !== 16'(pulses)) begin failures++; $display("FAIL pulse_count got=%0d exp=%0d", gcount, pulses); end
    endtask

    task automatic test_timing();
        do_reset();
        run_timeline(600, 1'b0);
    endtask

    task automatic test_passthrough();
        do_reset();
        en = 1'b0; min_gap = 8'd3; max_width = 4'hF;
        for (int i = 0; i < 100; i++) begin
            din = ((i / 7) % 2) != 0;
            cycle();
            checks++;
            if (dout !== din || ga !== 1'b0) begin
                failures++;
                $display("FAIL passthrough i=%0d got dout=%b ga=%b exp dout=%b ga=0", i, dout, ga, din);
            end
        end
    endtask

    task automatic test_model();
        int run_hi = 0;
        do_reset();
        en = 1'b1; min_gap = 8'd0; max_width = 4'hF;
        for (int i = 0; i < 5000; i++) begin
            din = 1'($urandom_range(0, 1));
            en  = !(i >= 2500 && i < 2505);
            cycle();
            if (ga) run_hi++;
            else begin
                if (run_hi != 0) begin
                    checks++;
                    if (run_hi < 1 || run_hi > 15) begin
                        failures++;
                        $display("FAIL glitch_width_range got=%0d exp=1..15", run_hi);
                    end
                end
                run_hi = 0;
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        en = 1'b1; din = 1'b0; min_gap = 8'd10; max_width = 4'd1;
        while (ga !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (ga !== 1'b1) begin failures++; $display("FAIL async_pre_glitch got ga=%b exp=1", ga); end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (dout !== 1'b0) begin failures++; $display("FAIL async_dout got=%b exp=0", dout); end
        checks++; if (ga !== 1'b0) begin failures++; $display("FAIL async_ga got=%b exp=0", ga); end
        checks++; if (gcount !== 16'h0) begin failures++; $display("FAIL async_count got=%h exp=0000", gcount); end
        #2;
        rst = 1'b1;
        run_timeline(600, 1'b1);
    endtask

    task automatic test_saturation();
        int          pulses = 0;
        int          n      = 0;
        logic [15:0] prev;
        logic        prev_ga = 1'b0;
        do_reset();
        en = 1'b1; din = 1'b0; min_gap = 8'd0; max_width = 4'd1;
        repeat (5) cycle();
        force dut.r_glitch_count = 16'hFFF0;
        m_count = 16'hFFF0;
        #1;
        release dut.r_glitch_count;
        prev = 16'hFFF0;
        while (pulses < 40 && n < 2000) begin
            cycle();
            n++;
            if (ga && !prev_ga) pulses++;
            prev_ga = ga;
            if (gcount < prev) begin
                checks++; failures++;
                $display("FAIL count_wrap got=%h prev=%h", gcount, prev);
            end
            prev = gcount;
        end
        checks++; if (pulses < 40) begin failures++; $display("FAIL sat_budget got=%0d exp=40 pulses", pulses); end
        checks++; if (gcount !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=ffff", gcount); end
    endtask

    initial begin
        test_reset();
        test_zero_width();
        test_timing();
        test_passthrough();
        test_model();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
